// File: rtl/clip_distortion_pkg.sv
// Shared mode constants, FSM state encoding and saturation-limit helpers for the clip distortion effect.
package clip_distortion_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_HARD   = 2'd1;
    localparam logic [1:0] MODE_SOFT   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PROC   = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/clip_distortion_effect_core.sv
// clip_channel_core: combinational pre-gain, saturation and bypass/hard/soft clip of one signed sample.
module clip_channel_core
    import clip_distortion_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int GAIN_WIDTH = 8,
    parameter int GAIN_FRAC  = 4,
    parameter int KNEE_SHIFT = 2
) (
    input  logic [DATA_WIDTH-1:0] i_x,
    input  logic [GAIN_WIDTH-1:0] i_gain,
    input  logic [DATA_WIDTH-1:0] i_teff,
    input  logic [1:0]            i_mode,
    output logic [DATA_WIDTH-1:0] o_y,
    output logic                  o_clipped
);

    localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam int SW = DATA_WIDTH + 2;
    localparam logic signed [PW-1:0] P_MAX = PW'(sat_max(DATA_WIDTH));
    localparam logic signed [PW-1:0] P_MIN = PW'(sat_min(DATA_WIDTH));
    localparam logic signed [SW-1:0] S_MAX = SW'(sat_max(DATA_WIDTH));
    localparam logic signed [SW-1:0] S_MIN = SW'(sat_min(DATA_WIDTH));

    logic signed [PW-1:0]         w_xe, w_ge, w_prod, w_shift;
    logic signed [DATA_WIDTH-1:0] w_g, w_t, w_tn, w_hard, w_soft;
    logic signed [SW-1:0]         w_gx, w_tx, w_abs, w_mag, w_soft_x;

    // Gain is unsigned, so it gets a zero sign bit before the signed multiply.
    assign w_xe    = {{(GAIN_WIDTH+1){i_x[DATA_WIDTH-1]}}, i_x};
    assign w_ge    = {{DATA_WIDTH{1'b0}}, 1'b0, i_gain};
    assign w_prod  = w_xe * w_ge;
    assign w_shift = w_prod >>> GAIN_FRAC;

    always_comb begin
        if (w_shift > P_MAX)
            w_g = P_MAX[DATA_WIDTH-1:0];
        else if (w_shift < P_MIN)
            w_g = P_MIN[DATA_WIDTH-1:0];
        else
            w_g = w_shift[DATA_WIDTH-1:0];
    end

    assign w_t    = i_teff;
    assign w_tn   = -w_t;
    assign w_hard = (w_g > w_t) ? w_t : ((w_g < w_tn) ? w_tn : w_g);

    // Extra headroom keeps |most-negative| exact.
    assign w_gx     = {{2{w_g[DATA_WIDTH-1]}}, w_g};
    assign w_tx     = {2'b00, w_t};
    assign w_abs    = w_gx[SW-1] ? -w_gx : w_gx;
    assign w_mag    = w_tx + ((w_abs - w_tx) >>> KNEE_SHIFT);
    assign w_soft_x = w_gx[SW-1] ? -w_mag : w_mag;

    always_comb begin
        if (w_abs <= w_tx)
            w_soft = w_g;
        else if (w_soft_x > S_MAX)
            w_soft = S_MAX[DATA_WIDTH-1:0];
        else if (w_soft_x < S_MIN)
            w_soft = S_MIN[DATA_WIDTH-1:0];
        else
            w_soft = w_soft_x[DATA_WIDTH-1:0];
    end

    always_comb begin
        o_y       = w_g;
        o_clipped = 1'b0;
        case (i_mode)
            MODE_HARD: begin
                o_y       = w_hard;
                o_clipped = (w_hard != w_g);
            end
            MODE_SOFT: begin
                o_y       = w_soft;
                o_clipped = (w_soft != w_g);
            end
            default: o_y = w_g;
        endcase
    end

endmodule

// File: rtl/clip_distortion_effect.sv
// Multi-channel clip distortion: capture a frame, clip one channel per cycle, hold until read done.
// Define CLIP_STATS_EN to add o_clip_count / o_clip_flag clip statistics.
module clip_distortion_effect
    import clip_distortion_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 2,
    parameter int GAIN_WIDTH = 8,
    parameter int GAIN_FRAC  = 4,
    parameter int KNEE_SHIFT = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CHANNELS*DATA_WIDTH-1:0] i_data,
    input  logic [DATA_WIDTH-1:0]          i_treshhold,
    input  logic [GAIN_WIDTH-1:0]          i_gain,
    input  logic [1:0]                     i_mode,
    input  logic                           i_data_ready,
    output logic                           o_read_enable,
    output logic [CHANNELS*DATA_WIDTH-1:0] o_data,
    output logic                           o_data_valid,
    input  logic                           i_read_done
`ifdef CLIP_STATS_EN
   ,output logic [31:0]                    o_clip_count,
    output logic                           o_clip_flag
`endif
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    state_t                         r_state, w_next;
    logic [CW-1:0]                  r_cnt;
    logic [CHANNELS*DATA_WIDTH-1:0] r_data, r_out;
    logic [DATA_WIDTH-1:0]          r_thr;
    logic [GAIN_WIDTH-1:0]          r_gain;
    logic [1:0]                     r_mode;
    logic                           r_valid, r_rd_en;
    logic                           w_last, w_clipped;
    logic [DATA_WIDTH-1:0]          w_teff, w_x, w_y;

    assign w_last = (r_cnt == CW'(CHANNELS - 1));
    assign w_teff = r_thr[DATA_WIDTH-1] ? '0 : r_thr;
    assign w_x    = r_data[r_cnt*DATA_WIDTH +: DATA_WIDTH];

    clip_channel_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .GAIN_WIDTH (GAIN_WIDTH),
        .GAIN_FRAC  (GAIN_FRAC),
        .KNEE_SHIFT (KNEE_SHIFT)
    ) u_core (
        .i_x       (w_x),
        .i_gain    (r_gain),
        .i_teff    (w_teff),
        .i_mode    (r_mode),
        .o_y       (w_y),
        .o_clipped (w_clipped)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_data_ready) w_next = PROC;
            PROC:    if (w_last) w_next = OUTPUT;
            // Release only once the frame has actually been presented.
            OUTPUT:  if (r_valid && i_read_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_data  <= '0;
            r_out   <= '0;
            r_thr   <= '0;
            r_gain  <= '0;
            r_mode  <= '0;
            r_valid <= 1'b0;
            r_rd_en <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_data_ready) begin
                        r_data  <= i_data;
                        r_thr   <= i_treshhold;
                        r_gain  <= i_gain;
                        r_mode  <= i_mode;
                        r_cnt   <= '0;
                        r_rd_en <= 1'b0;
                    end else begin
                        r_rd_en <= 1'b1;
                    end
                end
                PROC: begin
                    r_out[r_cnt*DATA_WIDTH +: DATA_WIDTH] <= w_y;
                    r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                end
                OUTPUT: begin
                    if (r_valid && i_read_done) begin
                        r_valid <= 1'b0;
                        r_rd_en <= 1'b1;
                    end else begin
                        r_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_data        = r_out;
    assign o_data_valid  = r_valid;
    assign o_read_enable = r_rd_en;

`ifdef CLIP_STATS_EN
    logic [31:0] r_clip_count;
    logic        r_clip_any;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clip_count <= '0;
            r_clip_any   <= 1'b0;
        end else if (r_state == IDLE && i_data_ready) begin
            r_clip_any <= 1'b0;
        end else if (r_state == PROC && w_clipped) begin
            r_clip_any <= 1'b1;
            if (r_clip_count != '1)
                r_clip_count <= r_clip_count + 32'd1;
        end
    end

    assign o_clip_count = r_clip_count;
    assign o_clip_flag  = (r_state == OUTPUT) && r_clip_any;
`else
    logic w_unused;
    assign w_unused = w_clipped;
`endif

endmodule

// File: tb/tb_clip_distortion_effect.sv
// Self-checking bench for clip_distortion_effect: directed cases plus randomized frames vs. an arithmetic model.
module tb_clip_distortion_effect;

    localparam int W  = 16;
    localparam int CH = 2;
    localparam int GW = 8;
    localparam int GF = 4;
    localparam int KS = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [CH*W-1:0] i_data;
    logic [W-1:0]    i_treshhold;
    logic [GW-1:0]   i_gain;
    logic [1:0]      i_mode;
    logic            i_data_ready;
    logic            o_read_enable;
    logic [CH*W-1:0] o_data;
    logic            o_data_valid;
    logic            i_read_done;
`ifdef CLIP_STATS_EN
    logic [31:0]     o_clip_count;
    logic            o_clip_flag;
    int              exp_count = 0;
`endif

    int checks = 0;
    int errors = 0;

    clip_distortion_effect #(
        .DATA_WIDTH (W),
        .CHANNELS   (CH),
        .GAIN_WIDTH (GW),
        .GAIN_FRAC  (GF),
        .KNEE_SHIFT (KS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_data        (i_data),
        .i_treshhold   (i_treshhold),
        .i_gain        (i_gain),
        .i_mode        (i_mode),
        .i_data_ready  (i_data_ready),
        .o_read_enable (o_read_enable),
        .o_data        (o_data),
        .o_data_valid  (o_data_valid),
        .i_read_done   (i_read_done)
`ifdef CLIP_STATS_EN
       ,.o_clip_count  (o_clip_count),
        .o_clip_flag   (o_clip_flag)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int gained(input int x, input int gain);
        return sat16((x * gain) >>> GF);
    endfunction

    function automatic int model(input int x, input int t, input int gain, input int mode);
        int g, te, a, m;
        g  = gained(x, gain);
        te = (t < 0) ? 0 : t;
        case (mode)
            1: return (g > te) ? te : ((g < -te) ? -te : g);
            2: begin
                a = (g < 0) ? -g : g;
                if (a <= te) return g;
                m = te + ((a - te) >> KS);
                return sat16((g < 0) ? -m : m);
            end
            default: return g;
        endcase
    endfunction

    function automatic logic [CH*W-1:0] model_frame(input logic [CH*W-1:0] d, input int t,
                                                    input int gain, input int mode);
        logic [CH*W-1:0]    r;
        logic signed [W-1:0] xs;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            xs = d[c*W +: W];
            r[c*W +: W] = W'(model(int'(xs), t, gain, mode));
        end
        return r;
    endfunction

    function automatic int model_clips(input logic [CH*W-1:0] d, input int t,
                                       input int gain, input int mode);
        logic signed [W-1:0] xs;
        int n;
        n = 0;
        for (int c = 0; c < CH; c++) begin
            xs = d[c*W +: W];
            if ((mode == 1 || mode == 2) &&
                model(int'(xs), t, gain, mode) != gained(int'(xs), gain))
                n++;
        end
        return n;
    endfunction

    // Full handshake for one frame, starting from IDLE; returns the observed frame.
    task automatic run_frame(input logic [CH*W-1:0] d, input int t, input int gain,
                             input int mode, input int hold, output logic [CH*W-1:0] got);
        logic [CH*W-1:0] exp;
        exp = model_frame(d, t, gain, mode);
        @(negedge clk);
        i_data       = d;
        i_treshhold  = W'(t);
        i_gain       = GW'(gain);
        i_mode       = 2'(mode);
        i_data_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_data_ready = 1'b0;
        i_data       = ~d;
        i_gain       = ~i_gain;
        i_mode       = ~i_mode;
        check("rd_en_low_after_capture", 64'(o_read_enable), 64'd0);
        for (int k = 1; k <= CH; k++) begin
            @(negedge clk);
            check("valid_not_early", 64'(o_data_valid), 64'd0);
        end
        @(negedge clk);
        check("valid_at_latency", 64'(o_data_valid), 64'd1);
        check("frame_data", 64'(o_data), 64'(exp));
`ifdef CLIP_STATS_EN
        exp_count += model_clips(d, t, gain, mode);
        check("clip_count", 64'(o_clip_count), 64'(exp_count));
        check("clip_flag", 64'(o_clip_flag), 64'(model_clips(d, t, gain, mode) != 0));
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("valid_held", 64'(o_data_valid), 64'd1);
            check("data_held", 64'(o_data), 64'(exp));
        end
        got = o_data;
        i_read_done = 1'b1;
        @(negedge clk);
        i_read_done = 1'b0;
        check("valid_cleared", 64'(o_data_valid), 64'd0);
        check("rd_en_after_done", 64'(o_read_enable), 64'd1);
        check("data_kept_after_done", 64'(o_data), 64'(exp));
    endtask

    initial begin
        logic [CH*W-1:0] got, d1, d2, e1, e2;
        int t, g, m;

        reset        = 1'b1;
        i_data       = '0;
        i_treshhold  = '0;
        i_gain       = '0;
        i_mode       = '0;
        i_data_ready = 1'b0;
        i_read_done  = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_data", 64'(o_data), 64'd0);
        check("reset_valid", 64'(o_data_valid), 64'd0);
        check("reset_rd_en", 64'(o_read_enable), 64'd0);
`ifdef CLIP_STATS_EN
        check("reset_clip_count", 64'(o_clip_count), 64'd0);
        check("reset_clip_flag", 64'(o_clip_flag), 64'd0);
`endif
        reset = 1'b0;
        @(negedge clk);
        check("idle_rd_en", 64'(o_read_enable), 64'd1);
        check("idle_valid", 64'(o_data_valid), 64'd0);

        // Hard clip, unity gain
        run_frame({16'(-5000), 16'(5000)}, 1000, 8'h10, 1, 3, got);
        check("hard_const", 64'(got), 64'h0000_0000_FC18_03E8);

        // Soft knee: 3000 -> 1000 + 2000/4
        run_frame({16'd0, 16'd3000}, 1000, 8'h10, 2, 0, got);
        check("soft_const", 64'(got), 64'h0000_0000_0000_05DC);

        // Soft knee on most-negative: |g| = 32768, 1000 + 31768/4 = 8942
        run_frame({16'd0, 16'h8000}, 1000, 8'h10, 2, 0, got);
        check("soft_minneg", 64'(got), 64'h0000_0000_0000_DD12);

        // Bypass with x4 gain saturates both ways
        run_frame({16'(-10000), 16'(10000)}, 1000, 8'h40, 0, 0, got);
        check("gain_sat", 64'(got), 64'h0000_0000_8000_7FFF);

        // Negative threshold in hard mode zeroes everything
        run_frame({16'h1234, 16'hF00D}, -5, 8'h10, 1, 0, got);
        check("teff_zero", 64'(got), 64'd0);

        // Reserved mode acts as bypass
        run_frame({16'd300, 16'(-700)}, 10, 8'h10, 3, 0, got);
        check("reserved_bypass", 64'(got), 64'h0000_0000_012C_FD44);

        // Reset during PROC aborts the frame
        @(negedge clk);
        i_data       = {16'd4000, 16'd4000};
        i_treshhold  = 16'd100;
        i_gain       = 8'h10;
        i_mode       = 2'd1;
        i_data_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_data_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_data", 64'(o_data), 64'd0);
        check("abort_valid", 64'(o_data_valid), 64'd0);
        check("abort_rd_en", 64'(o_read_enable), 64'd0);
`ifdef CLIP_STATS_EN
        exp_count = 0;
`endif
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("abort_valid_stays_low", 64'(o_data_valid), 64'd0);
        end
        run_frame({16'(-5000), 16'(5000)}, 1000, 8'h10, 1, 0, got);
        check("after_abort", 64'(got), 64'h0000_0000_FC18_03E8);

        // i_data_ready held during OUTPUT must not recapture
        d1 = {16'd2000, 16'(-2000)};
        d2 = {16'd50, 16'd60};
        e1 = model_frame(d1, 500, 16, 1);
        e2 = model_frame(d2, 500, 32, 0);
        @(negedge clk);
        i_data       = d1;
        i_treshhold  = 16'd500;
        i_gain       = 8'h10;
        i_mode       = 2'd1;
        i_data_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_data_ready = 1'b0;
        repeat (CH + 1) @(negedge clk);
        check("rc_valid", 64'(o_data_valid), 64'd1);
        check("rc_first", 64'(o_data), 64'(e1));
        i_data       = d2;
        i_gain       = 8'h20;
        i_mode       = 2'd0;
        i_data_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rc_no_recapture", 64'(o_data), 64'(e1));
            check("rc_rd_en_low", 64'(o_read_enable), 64'd0);
        end
        i_read_done = 1'b1;
        @(negedge clk);
        i_read_done = 1'b0;
        check("rc_back_idle", 64'(o_read_enable), 64'd1);
        @(negedge clk);
        i_data_ready = 1'b0;
        check("rc_captured", 64'(o_read_enable), 64'd0);
        repeat (CH + 1) @(negedge clk);
        check("rc_second_valid", 64'(o_data_valid), 64'd1);
        check("rc_second", 64'(o_data), 64'(e2));
`ifdef CLIP_STATS_EN
        exp_count += model_clips(d1, 500, 16, 1) + model_clips(d2, 500, 32, 0);
        check("rc_clip_count", 64'(o_clip_count), 64'(exp_count));
`endif
        i_read_done = 1'b1;
        @(negedge clk);
        i_read_done = 1'b0;

        // Randomized frames
        for (int n = 0; n < 30; n++) begin
            d1 = {16'($urandom), 16'($urandom)};
            t  = int'($urandom_range(0, 40000)) - 6000;
            g  = int'($urandom_range(0, 255));
            m  = int'($urandom_range(0, 3));
            if (t > 32767) t = 32767;
            run_frame(d1, t, g, m, int'($urandom_range(0, 2)), got);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
